register_bank: RTL and testbench

- 32 x 16-bit general-purpose register file sitting directly downstream of the write-back stage.
- Consumes the stage's DATA_OUT, ADDR_REG_OUT and COND outputs as its write port.
- Provides two combinational read ports, with write-through bypass, to decode/operand fetch.
- Keeps a per-register pending-write scoreboard. Decode uses it to detect RAW hazards (operand not yet written) and WAW hazards (destination already has a pending write).

---
 rtl/register_bank_if.sv | 32 +++
 rtl/register_bank.sv | 88 ++++++++
 tb/tb_register_bank.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/register_bank_if.sv
// Write-back, operand-read and issue signals of the register bank.
// master = write-back/decode side, slave = register bank.
interface register_bank_if #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5
);
    logic [DATA_W-1:0] WB_DATA_IN;
    logic [ADDR_W-1:0] WB_ADDR_IN;
    logic              WB_COND_IN;
    logic [ADDR_W-1:0] RD_ADDR_A;
    logic [ADDR_W-1:0] RD_ADDR_B;
    logic [DATA_W-1:0] DATA_A;
    logic [DATA_W-1:0] DATA_B;
    logic              ISSUE_EN;
    logic [ADDR_W-1:0] ISSUE_ADDR;
    logic              BUSY_A;
    logic              BUSY_B;
    logic              STALL;
    logic              IDLE_OUT;

    modport master (
        output WB_DATA_IN, WB_ADDR_IN, WB_COND_IN,
        output RD_ADDR_A, RD_ADDR_B, ISSUE_EN, ISSUE_ADDR,
        input  DATA_A, DATA_B, BUSY_A, BUSY_B, STALL, IDLE_OUT
    );

    modport slave (
        input  WB_DATA_IN, WB_ADDR_IN, WB_COND_IN,
        input  RD_ADDR_A, RD_ADDR_B, ISSUE_EN, ISSUE_ADDR,
        output DATA_A, DATA_B, BUSY_A, BUSY_B, STALL, IDLE_OUT
    );
endinterface

// File: rtl/register_bank.sv
// 32 x 16 register file with write-through bypass and a
// pending-write scoreboard for RAW/WAW hazard detection.
module register_bank #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 5,
    parameter int NREGS  = 32
) (
    input logic           CLOCK,
    input logic           RST,
    register_bank_if.slave bus
);
    logic [DATA_W-1:0] regs [NREGS];
    logic [NREGS-1:0]  busy;
    logic [NREGS-1:0]  busy_next;
    logic              wr;
    logic              waw;
    logic              issue_ok;
    logic              hit_a;
    logic              hit_b;

    assign wr    = bus.WB_COND_IN && (bus.WB_ADDR_IN != '0);
    assign hit_a = bus.WB_COND_IN && (bus.WB_ADDR_IN == bus.RD_ADDR_A);
    assign hit_b = bus.WB_COND_IN && (bus.WB_ADDR_IN == bus.RD_ADDR_B);

    // a write landing this cycle releases the destination, so no WAW
    assign waw = bus.ISSUE_EN
              && (bus.ISSUE_ADDR != '0)
              && busy[bus.ISSUE_ADDR]
              && !(wr && (bus.WB_ADDR_IN == bus.ISSUE_ADDR));

    assign issue_ok = bus.ISSUE_EN
                   && (bus.ISSUE_ADDR != '0)
                   && !waw;

    // clear on write first, then set on issue so the new producer wins
    always_comb begin
        busy_next = busy;
        if (wr) begin
            busy_next[bus.WB_ADDR_IN] = 1'b0;
        end
        if (issue_ok) begin
            busy_next[bus.ISSUE_ADDR] = 1'b1;
        end
    end

    // scoreboard state
    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            busy <= '0;
        end else begin
            busy <= busy_next;
        end
    end

    // register storage; entry 0 is never written and stays zero
    always_ff @(posedge CLOCK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < NREGS; i++) begin
                regs[i] <= '0;
            end
        end else if (wr) begin
            regs[bus.WB_ADDR_IN] <= bus.WB_DATA_IN;
        end
    end

    // read port A with bypass of the write in flight
    always_comb begin
        bus.DATA_A = '0;
        if (RST && (bus.RD_ADDR_A != '0)) begin
            bus.DATA_A = hit_a ? bus.WB_DATA_IN
                               : regs[bus.RD_ADDR_A];
        end
    end

    // read port B with bypass of the write in flight
    always_comb begin
        bus.DATA_B = '0;
        if (RST && (bus.RD_ADDR_B != '0)) begin
            bus.DATA_B = hit_b ? bus.WB_DATA_IN
                               : regs[bus.RD_ADDR_B];
        end
    end

    assign bus.BUSY_A   = RST && busy[bus.RD_ADDR_A] && !hit_a;
    assign bus.BUSY_B   = RST && busy[bus.RD_ADDR_B] && !hit_b;
    assign bus.STALL    = RST && waw;
    assign bus.IDLE_OUT = !RST || (busy == '0);
endmodule

// File: tb/tb_register_bank.sv
// Scoreboard bench for register_bank: a reference model predicts
// every output cycle, predictions are queued and popped at sampling.
module tb_register_bank;
    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    register_bank_if bus ();

    register_bank dut (
        .CLOCK (clk),
        .RST   (rst_n),
        .bus   (bus)
    );

    typedef struct {
        logic [15:0] da;
        logic [15:0] db;
        logic        ba;
        logic        bb;
        logic        st;
        logic        idle;
    } exp_t;

    exp_t        q[$];
    logic [15:0] m_reg [32];
    logic [31:0] m_busy;
    int          passed = 0;
    int          total  = 0;

    task automatic check(input string tag,
                         input logic [15:0] obs,
                         input logic [15:0] exp);
        total++;
        if (obs === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_reg[i] = '0;
        m_busy = '0;
    endtask

    function automatic exp_t predict();
        exp_t e;
        logic wr;
        wr = bus.WB_COND_IN && bus.WB_ADDR_IN != 0;
        e.da = '0;
        e.db = '0;
        e.ba = 1'b0;
        e.bb = 1'b0;
        e.st = 1'b0;
        e.idle = 1'b1;
        if (rst_n) begin
            if (bus.RD_ADDR_A != 0)
                e.da = (wr && bus.WB_ADDR_IN == bus.RD_ADDR_A)
                     ? bus.WB_DATA_IN : m_reg[bus.RD_ADDR_A];
            if (bus.RD_ADDR_B != 0)
                e.db = (wr && bus.WB_ADDR_IN == bus.RD_ADDR_B)
                     ? bus.WB_DATA_IN : m_reg[bus.RD_ADDR_B];
            e.ba = m_busy[bus.RD_ADDR_A]
                && !(bus.WB_COND_IN && bus.WB_ADDR_IN == bus.RD_ADDR_A);
            e.bb = m_busy[bus.RD_ADDR_B]
                && !(bus.WB_COND_IN && bus.WB_ADDR_IN == bus.RD_ADDR_B);
            e.st = bus.ISSUE_EN && bus.ISSUE_ADDR != 0
                && m_busy[bus.ISSUE_ADDR]
                && !(wr && bus.WB_ADDR_IN == bus.ISSUE_ADDR);
            e.idle = (m_busy == 0);
        end
        return e;
    endfunction

    task automatic model_edge();
        logic wr;
        logic st;
        wr = bus.WB_COND_IN && bus.WB_ADDR_IN != 0;
        st = bus.ISSUE_EN && bus.ISSUE_ADDR != 0
          && m_busy[bus.ISSUE_ADDR]
          && !(wr && bus.WB_ADDR_IN == bus.ISSUE_ADDR);
        if (!rst_n) return;
        if (wr) begin
            m_reg[bus.WB_ADDR_IN] = bus.WB_DATA_IN;
            m_busy[bus.WB_ADDR_IN] = 1'b0;
        end
        if (bus.ISSUE_EN && bus.ISSUE_ADDR != 0 && !st)
            m_busy[bus.ISSUE_ADDR] = 1'b1;
    endtask

    task automatic compare_pop();
        exp_t e;
        if (q.size() == 0) begin
            check("queue_underflow", 16'd0, 16'd1);
            return;
        end
        e = q.pop_front();
        check("data_a", bus.DATA_A, e.da);
        check("data_b", bus.DATA_B, e.db);
        check("busy_a", {15'd0, bus.BUSY_A}, {15'd0, e.ba});
        check("busy_b", {15'd0, bus.BUSY_B}, {15'd0, e.bb});
        check("stall", {15'd0, bus.STALL}, {15'd0, e.st});
        check("idle", {15'd0, bus.IDLE_OUT}, {15'd0, e.idle});
    endtask

    // drive one cycle: inputs at negedge, sample 1 ns later
    task automatic drive(input logic [15:0] wd,
                         input logic [4:0]  wa,
                         input logic        wc,
                         input logic [4:0]  ra,
                         input logic [4:0]  rb,
                         input logic        ie,
                         input logic [4:0]  ia);
        @(negedge clk);
        bus.WB_DATA_IN = wd;
        bus.WB_ADDR_IN = wa;
        bus.WB_COND_IN = wc;
        bus.RD_ADDR_A  = ra;
        bus.RD_ADDR_B  = rb;
        bus.ISSUE_EN   = ie;
        bus.ISSUE_ADDR = ia;
        q.push_back(predict());
        #1;
        compare_pop();
        model_edge();
    endtask

    // assert reset between edges and sample before any edge arrives
    task automatic async_reset();
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        q.push_back(predict());
        #1;
        compare_pop();
    endtask

    initial begin
        bus.WB_DATA_IN = '0;
        bus.WB_ADDR_IN = '0;
        bus.WB_COND_IN = 1'b0;
        bus.RD_ADDR_A  = '0;
        bus.RD_ADDR_B  = '0;
        bus.ISSUE_EN   = 1'b0;
        bus.ISSUE_ADDR = '0;
        model_reset();
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        drive(16'h1111, 5, 1, 5, 31, 0, 0);
        drive(16'h0000, 0, 0, 5, 31, 0, 0);
        check("pre_reset_r5", bus.DATA_A, 16'h1111);
        async_reset();
        check("async_rst_a", bus.DATA_A, 16'h0000);
        check("async_rst_idle", {15'd0, bus.IDLE_OUT}, 16'd1);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 5, 31, 0, 0);
        check("r5_after_rst", bus.DATA_A, 16'h0000);
        check("r31_after_rst", bus.DATA_B, 16'h0000);

        drive(16'hBEEF, 7, 1, 7, 0, 0, 0);
        check("bypass_r7", bus.DATA_A, 16'hBEEF);
        drive(16'h0000, 0, 0, 7, 7, 0, 0);
        check("stored_r7", bus.DATA_A, 16'hBEEF);
        check("stored_r7_b", bus.DATA_B, 16'hBEEF);

        drive(16'h1234, 0, 1, 0, 0, 0, 0);
        check("r0_bypass", bus.DATA_A, 16'h0000);
        drive(16'h0000, 0, 0, 0, 0, 1, 0);
        check("r0_read", bus.DATA_A, 16'h0000);
        check("r0_issue_stall", {15'd0, bus.STALL}, 16'd0);
        drive(0, 0, 0, 0, 0, 0, 0);
        check("r0_issue_idle", {15'd0, bus.IDLE_OUT}, 16'd1);

        drive(0, 0, 0, 3, 0, 1, 3);
        drive(0, 0, 0, 3, 0, 1, 3);
        check("r3_busy", {15'd0, bus.BUSY_A}, 16'd1);
        check("r3_not_idle", {15'd0, bus.IDLE_OUT}, 16'd0);
        check("r3_waw_stall", {15'd0, bus.STALL}, 16'd1);
        drive(16'h0042, 3, 1, 3, 0, 0, 0);
        check("r3_clr_busy", {15'd0, bus.BUSY_A}, 16'd0);
        check("r3_clr_data", bus.DATA_A, 16'h0042);
        check("r3_clr_still_busy_st", {15'd0, bus.IDLE_OUT}, 16'd0);
        drive(0, 0, 0, 3, 0, 0, 0);
        check("r3_idle_after", {15'd0, bus.IDLE_OUT}, 16'd1);

        drive(0, 0, 0, 9, 0, 1, 9);
        drive(16'h00AA, 9, 1, 9, 0, 1, 9);
        check("r9_no_stall", {15'd0, bus.STALL}, 16'd0);
        check("r9_bypass", bus.DATA_A, 16'h00AA);
        drive(0, 0, 0, 9, 0, 0, 0);
        check("r9_rebusy", {15'd0, bus.BUSY_A}, 16'd1);
        check("r9_data", bus.DATA_A, 16'h00AA);
        drive(16'h0001, 9, 1, 0, 0, 0, 0);

        drive(16'hFFFF, 4, 1, 0, 0, 1, 4);
        drive(0, 0, 0, 4, 12, 1, 12);
        drive(0, 0, 0, 4, 12, 0, 0);
        check("r4_busy", {15'd0, bus.BUSY_A}, 16'd1);
        check("r12_busy", {15'd0, bus.BUSY_B}, 16'd1);
        check("r4_data", bus.DATA_A, 16'hFFFF);
        async_reset();
        check("rst_busy_a", {15'd0, bus.BUSY_A}, 16'd0);
        check("rst_busy_b", {15'd0, bus.BUSY_B}, 16'd0);
        check("rst_r4", bus.DATA_A, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 4, 12, 0, 0);
        check("rst_idle", {15'd0, bus.IDLE_OUT}, 16'd1);
        check("rst_r4_after", bus.DATA_A, 16'h0000);

        for (int i = 0; i < 400; i++) begin
            drive(16'($urandom),
                  5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 7)));
        end

        check("queue_empty", 16'(q.size()), 16'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end
endmodule
